// File: rtl/pe_exp_acc_seq.sv
// Sequencer for a linear chain of exp-accumulator PEs: clears the chain, streams
// one row of terms, drains the pipeline, then offers the tail sum downstream.
module pe_exp_acc_seq #(
  parameter int NUM_PE      = 4,
  parameter int ROW_LEN_MAX = 1024,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = $clog2(ROW_LEN_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  row_len_i,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pe_do_process,
  output logic              pe_clear,
  output logic              pe_bubble,
  input  logic [DATA_W-1:0] sum_in,
  output logic [DATA_W-1:0] sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_HOLD   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    drain_q, drain_d;
  logic [DATA_W-1:0]   sum_q, sum_d;

  // Handshakes: a transfer happens on a cycle where both valid and ready are
  // high; valid never depends on ready, and sum_valid stays up until taken.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    drain_d       = drain_q;
    sum_d         = sum_q;
    in_ready      = 1'b0;
    pe_do_process = 1'b0;
    pe_clear      = 1'b0;
    pe_bubble     = 1'b0;
    done          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (row_len_i != '0) begin
            len_d   = (row_len_i > LEN_W'(ROW_LEN_MAX)) ? LEN_W'(ROW_LEN_MAX) : row_len_i;
            state_d = S_CLEAR;
          end else begin
            sum_d   = '0;
            state_d = S_HOLD;
          end
        end
      end
      S_CLEAR: begin
        pe_clear = 1'b1;
        cnt_d    = '0;
        state_d  = S_STREAM;
      end
      S_STREAM: begin
        in_ready      = 1'b1;
        pe_do_process = in_valid;
        if (in_valid) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            drain_d = LEN_W'(NUM_PE - 1);
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        pe_do_process = 1'b1;
        pe_bubble     = 1'b1;
        // The tail already shows the final sum during the last drain cycle.
        if (drain_q == '0) begin
          sum_d   = sum_in;
          state_d = S_HOLD;
        end else begin
          drain_d = drain_q - LEN_W'(1);
        end
      end
      S_HOLD: begin
        if (sum_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a HOLD handshake or a final capture.
    if (abort && (state_q != S_IDLE)) begin
      state_d       = S_IDLE;
      pe_clear      = 1'b1;
      in_ready      = 1'b0;
      pe_do_process = 1'b0;
      pe_bubble     = 1'b0;
      done          = 1'b0;
      sum_d         = sum_q;
      cnt_d         = '0;
      drain_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      sum_q   <= sum_d;
    end
  end

  assign sum_out   = sum_q;
  assign sum_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pe_exp_acc_seq.sv
// Directed bench for pe_exp_acc_seq: inputs change on the falling edge and
// outputs are checked 1 time unit later, away from the rising edge.
module tb_pe_exp_acc_seq;
  localparam int NUM_PE = 4;
  localparam int LEN_W  = 11;
  localparam int DATA_W = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              abort;
  logic [LEN_W-1:0]  row_len_i;
  logic              in_valid;
  logic              in_ready;
  logic              pe_do_process;
  logic              pe_clear;
  logic              pe_bubble;
  logic [DATA_W-1:0] sum_in;
  logic [DATA_W-1:0] sum_out;
  logic              sum_valid;
  logic              sum_ready;
  logic              busy;
  logic              done;
  logic [2:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  pe_exp_acc_seq #(.NUM_PE(NUM_PE), .ROW_LEN_MAX(1024), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .row_len_i(row_len_i),
    .in_valid(in_valid), .in_ready(in_ready), .pe_do_process(pe_do_process),
    .pe_clear(pe_clear), .pe_bubble(pe_bubble), .sum_in(sum_in), .sum_out(sum_out),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a job of length len (>0) and steps until sum_valid or a cycle budget.
  task automatic run_job(input logic [LEN_W-1:0] len, input bit toggle,
                         output int acc, output int dp, output int bub,
                         output int lat, output int bad, output bit ok);
    int last_acc;
    acc = 0; dp = 0; bub = 0; lat = -1; bad = 0; ok = 1'b0; last_acc = -1;
    @(negedge clk);
    start = 1'b1; row_len_i = len; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("clear_cycle", {30'd0, pe_clear, pe_do_process}, 32'h2);
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      in_valid = toggle ? (k % 2 == 0) : 1'b1;
      #1;
      if (sum_valid) begin
        lat = k - last_acc;
        ok  = 1'b1;
        break;
      end
      if (in_ready && in_valid) begin
        acc++;
        last_acc = k;
      end
      if (pe_do_process) dp++;
      if (pe_bubble) begin
        bub++;
        if (in_ready || !pe_do_process) bad++;
      end else if (pe_do_process !== in_valid) begin
        bad++;
      end
    end
    in_valid = 1'b0;
    chk("job_reached_hold", {31'd0, ok}, 32'd1);
  endtask

  task automatic take_sum(input string tag);
    @(negedge clk);
    sum_ready = 1'b1;
    #1;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    @(negedge clk);
    sum_ready = 1'b0;
    #1;
    chk({tag, "_idle"}, {28'd0, busy, dbg_state}, {29'd0, ST_IDLE});
    chk({tag, "_valid_low"}, {30'd0, sum_valid, done}, 32'd0);
  endtask

  initial begin
    int acc, dp, bub, lat, bad;
    bit ok;
    logic [DATA_W-1:0] held;

    reset = 1'b0; start = 1'b0; abort = 1'b0; row_len_i = '0;
    in_valid = 1'b0; sum_in = '0; sum_ready = 1'b0;
    #2;
    chk("reset_outs", {25'd0, in_ready, pe_do_process, pe_clear, pe_bubble,
                       sum_valid, busy, done}, 32'd0);
    chk("reset_sum_out", sum_out, 32'd0);
    chk("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    @(negedge clk);
    reset = 1'b1;

    // Job of 3 with in_valid held high.
    sum_in = 32'h1234_5678;
    run_job(11'd3, 1'b0, acc, dp, bub, lat, bad, ok);
    chk("t1_accepts", acc, 3);
    chk("t1_do_process_cycles", dp, 7);
    chk("t1_bubbles", bub, NUM_PE);
    chk("t1_latency", lat, 5);
    chk("t1_protocol", bad, 0);
    chk("t1_sum_out", sum_out, 32'h1234_5678);
    chk("t1_hold_no_process", {31'd0, pe_do_process}, 32'd0);
    take_sum("t1");
    chk("t1_sum_kept_idle", sum_out, 32'h1234_5678);

    // Job of 4 with in_valid toggling, then a long HOLD stall.
    sum_in = 32'h0BAD_F00D;
    run_job(11'd4, 1'b1, acc, dp, bub, lat, bad, ok);
    chk("t2_accepts", acc, 4);
    chk("t2_do_process_cycles", dp, 8);
    chk("t2_bubbles", bub, NUM_PE);
    chk("t2_protocol", bad, 0);
    chk("t2_latency", lat, 5);
    held = sum_out;
    chk("t2_sum_out", held, 32'h0BAD_F00D);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      sum_in = 32'hFFFF_0000 + k;
      start = (k == 3);
      row_len_i = 11'd5;
      #1;
      if (!sum_valid || pe_do_process || pe_clear || sum_out !== held) bad++;
    end
    start = 1'b0;
    chk("t2_hold_stable", bad, 0);
    chk("t2_still_hold", {29'd0, dbg_state}, {29'd0, ST_HOLD});
    take_sum("t2");

    // Zero-length row: no clear, no processing, sum forced to 0.
    @(negedge clk);
    start = 1'b1; row_len_i = 11'd0;
    #1;
    chk("t3_no_clear", {30'd0, pe_clear, pe_do_process}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("t3_valid", {31'd0, sum_valid}, 32'd1);
    chk("t3_sum_zero", sum_out, 32'd0);
    chk("t3_quiet", {30'd0, pe_clear, pe_do_process}, 32'd0);
    take_sum("t3");

    // Oversize row clamps to 1024.
    sum_in = 32'h0000_0400;
    run_job(11'd2000, 1'b0, acc, dp, bub, lat, bad, ok);
    chk("t4_accepts_clamped", acc, 1024);
    chk("t4_latency", lat, 5);
    take_sum("t4");

    // Abort in STREAM after 2 of 8 terms.
    @(negedge clk);
    start = 1'b1; row_len_i = 11'd8;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
    end
    @(negedge clk);
    abort = 1'b1;
    #1;
    chk("t5_abort_clear", {29'd0, pe_clear, in_ready, pe_do_process}, 32'h4);
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("t5_abort_idle", {28'd0, busy, dbg_state}, {29'd0, ST_IDLE});
    chk("t5_abort_quiet", {29'd0, pe_clear, sum_valid, in_ready}, 32'd0);
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("t5_no_sum_valid", {31'd0, sum_valid}, 32'd0);

    // Abort coinciding with sum_ready in HOLD.
    sum_in = 32'h0000_0011;
    run_job(11'd1, 1'b0, acc, dp, bub, lat, bad, ok);
    chk("t5_len1_latency", lat, 5);
    @(negedge clk);
    abort = 1'b1; sum_ready = 1'b1;
    #1;
    chk("t5_hold_abort", {30'd0, done, pe_clear}, 32'h1);
    @(negedge clk);
    sum_ready = 1'b0;
    #1;
    chk("t5_hold_abort_idle", {29'd0, sum_valid, dbg_state}, {29'd0, ST_IDLE});
    chk("t5_idle_abort_noop", {30'd0, pe_clear, busy}, 32'd0);
    @(negedge clk);
    abort = 1'b0;

    // Asynchronous reset in the middle of DRAIN.
    sum_in = 32'h0000_0022;
    @(negedge clk);
    start = 1'b1; row_len_i = 11'd3;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (dbg_state == ST_DRAIN) begin
        ok = 1'b1;
        break;
      end
    end
    chk("t6_reached_drain", {31'd0, ok}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_reset_outs", {25'd0, in_ready, pe_do_process, pe_clear, pe_bubble,
                          sum_valid, busy, done}, 32'd0);
    chk("t6_reset_sum", sum_out, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sum_in = 32'hCAFE_0003;
    run_job(11'd3, 1'b0, acc, dp, bub, lat, bad, ok);
    chk("t6_accepts", acc, 3);
    chk("t6_latency", lat, 5);
    chk("t6_sum_out", sum_out, 32'hCAFE_0003);
    take_sum("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
